// File: rtl/number_grid_display.sv
// number_grid_display
//   Draws a ROWS x COLS grid of 16x32 digit sprites. Each column scrolls
//   horizontally with its own signed fixed-point speed and wraps modulo
//   SCREEN_W. A cell hides for HIDE_FRAMES frames after a hit, blinks during
//   the last BLINK_FRAMES of that window, then becomes collidable again.
//   Accepted hits add the cell digit value to a saturating 16-bit score.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   startOfFrame    one-cycle pulse per frame (advances motion and timers)
//   pixelX, pixelY  current VGA coordinate
//   digits          4-bit digit per cell (cell k = r*COLS + c); 10-15 blank
//   colSpeed        signed 32-bit speed per column, pixels * 2^FRAC per frame
//   singleHit       level collision flag per cell
//   cellDR          registered per-cell draw request (1-cycle latency)
//   anyDR, rgbOut   merged draw request and colour of lowest requesting cell
//   showMask        1 = cell is collidable (VISIBLE)
//   hitPulse        one-cycle pulse after any accepted hit
//   hitIdx          lowest accepted hit index, held until the next hit
//   score           saturating sum of collected digit values
module number_grid_display #(
    parameter int          ROWS         = 3,
    parameter int          COLS         = 2,
    parameter int          NUM_CELLS    = ROWS * COLS,
    parameter int          INITIAL_X    = 150,
    parameter int          X_PITCH      = 50,
    parameter int          Y0           = 100,
    parameter int          Y_PITCH      = 100,
    parameter int          SPRITE_W     = 16,
    parameter int          SPRITE_H     = 32,
    parameter int          SCREEN_W     = 640,
    parameter int          FRAC         = 6,
    parameter int          HIDE_FRAMES  = 450,
    parameter int          BLINK_FRAMES = 64,
    parameter logic [7:0]  DIGIT_RGB    = 8'hFF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         startOfFrame,
    input  logic [10:0]                  pixelX,
    input  logic [10:0]                  pixelY,
    input  logic [NUM_CELLS*4-1:0]       digits,
    input  logic [COLS*32-1:0]           colSpeed,
    input  logic [NUM_CELLS-1:0]         singleHit,
    output logic [NUM_CELLS-1:0]         cellDR,
    output logic                         anyDR,
    output logic [7:0]                   rgbOut,
    output logic [NUM_CELLS-1:0]         showMask,
    output logic                         hitPulse,
    output logic [$clog2(NUM_CELLS)-1:0] hitIdx,
    output logic [15:0]                  score
);

    localparam int IDX_W  = $clog2(NUM_CELLS);
    localparam int TW_MIN = $clog2(HIDE_FRAMES + 1);
    localparam int TW     = (TW_MIN > 9) ? TW_MIN : 9;
    localparam logic signed [33:0] WRAP = 34'(SCREEN_W * (2 ** FRAC));

    typedef enum logic [1:0] {ST_VIS, ST_HID, ST_BLK} cell_st_t;

    logic [31:0]          x_q   [COLS];
    logic [31:0]          x_d   [COLS];
    cell_st_t             st_q  [NUM_CELLS];
    cell_st_t             st_d  [NUM_CELLS];
    logic [TW-1:0]        tmr_q [NUM_CELLS];
    logic [TW-1:0]        tmr_d [NUM_CELLS];
    logic [NUM_CELLS-1:0] hit_prev_q;
    logic [NUM_CELLS-1:0] acc;
    logic [NUM_CELLS-1:0] cell_dr_q, cell_dr_d;
    logic                 any_dr_q, any_dr_d;
    logic [7:0]           rgb_q, rgb_d;
    logic                 hit_pulse_q, hit_pulse_d;
    logic [IDX_W-1:0]     hit_idx_q, hit_idx_d;
    logic [15:0]          score_q, score_d;

    // Segment enables {g,f,e,d,c,b,a} of the seven-segment font.
    function automatic logic [6:0] seg_map(input logic [3:0] d);
        case (d)
            4'd0:    seg_map = 7'b0111111;
            4'd1:    seg_map = 7'b0000110;
            4'd2:    seg_map = 7'b1011011;
            4'd3:    seg_map = 7'b1001111;
            4'd4:    seg_map = 7'b1100110;
            4'd5:    seg_map = 7'b1101101;
            4'd6:    seg_map = 7'b1111101;
            4'd7:    seg_map = 7'b0000111;
            4'd8:    seg_map = 7'b1111111;
            4'd9:    seg_map = 7'b1101111;
            default: seg_map = 7'b0000000;
        endcase
    endfunction

    // Shared digit ROM: 16x32 font with 4-pixel-thick segments.
    function automatic logic digit_pixel(input logic [3:0] d,
                                         input logic [3:0] ox,
                                         input logic [4:0] oy);
        logic [6:0] on;
        on[0] = (oy <= 5'd3) && (ox >= 4'd2) && (ox <= 4'd13);
        on[1] = (ox >= 4'd12) && (oy >= 5'd2) && (oy <= 5'd15);
        on[2] = (ox >= 4'd12) && (oy >= 5'd16) && (oy <= 5'd29);
        on[3] = (oy >= 5'd28) && (ox >= 4'd2) && (ox <= 4'd13);
        on[4] = (ox <= 4'd3) && (oy >= 5'd16) && (oy <= 5'd29);
        on[5] = (ox <= 4'd3) && (oy >= 5'd2) && (oy <= 5'd15);
        on[6] = (oy >= 5'd14) && (oy <= 5'd17) && (ox >= 4'd2) && (ox <= 4'd13);
        return |(seg_map(d) & on);
    endfunction

    // One frame of motion; speed magnitude is assumed < one screen width.
    function automatic logic [31:0] wrap_step(input logic [31:0] x,
                                              input logic [31:0] spd);
        logic signed [33:0] t;
        t = $signed({{2{x[31]}}, x}) + $signed({{2{spd[31]}}, spd});
        if (t >= WRAP)
            t = t - WRAP;
        else if (t < 34'sd0)
            t = t + WRAP;
        return t[31:0];
    endfunction

    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            x_d[c] = x_q[c];
            if (startOfFrame)
                x_d[c] = wrap_step(x_q[c], colSpeed[c*32 +: 32]);
        end
    end

    always_comb begin : cell_comb
        logic [10:0] x_int, y_top, off_x, off_y;
        logic [3:0]  dig;
        logic        in_x, in_y, drawn;
        logic [15:0] hit_sum;
        logic [16:0] score_sum;
        x_int     = '0;
        y_top     = '0;
        off_x     = '0;
        off_y     = '0;
        dig       = '0;
        in_x      = 1'b0;
        in_y      = 1'b0;
        drawn     = 1'b0;
        hit_sum   = '0;
        acc       = '0;
        cell_dr_d = '0;
        rgb_d     = '0;
        hit_idx_d = hit_idx_q;
        for (int k = 0; k < NUM_CELLS; k++) begin
            dig    = digits[k*4 +: 4];
            // Rising edge only: a level held across reappearance stays ignored.
            acc[k] = singleHit[k] & ~hit_prev_q[k] & (st_q[k] == ST_VIS);

            st_d[k]  = st_q[k];
            tmr_d[k] = tmr_q[k];
            if (acc[k]) begin
                st_d[k]  = ST_HID;
                tmr_d[k] = TW'(HIDE_FRAMES);
            end else if (st_q[k] != ST_VIS && startOfFrame) begin
                tmr_d[k] = tmr_q[k] - 1'b1;
                if (tmr_d[k] == '0)
                    st_d[k] = ST_VIS;
                else if (tmr_d[k] <= TW'(BLINK_FRAMES))
                    st_d[k] = ST_BLK;
            end

            if (acc[k] && dig <= 4'd9)
                hit_sum = hit_sum + 16'(dig);

            // Sprite is clipped at the right edge rather than split across it.
            x_int = x_q[k % COLS][FRAC +: 11];
            y_top = 11'(Y0 + (k / COLS) * Y_PITCH);
            off_x = pixelX - x_int;
            off_y = pixelY - y_top;
            in_x  = (pixelX >= x_int) && (off_x < 11'(SPRITE_W)) &&
                    (pixelX < 11'(SCREEN_W));
            in_y  = (pixelY >= y_top) && (off_y < 11'(SPRITE_H));
            drawn = (st_q[k] == ST_VIS) || (st_q[k] == ST_BLK && tmr_q[k][3]);
            cell_dr_d[k] = in_x && in_y && drawn &&
                           digit_pixel(dig, off_x[3:0], off_y[4:0]);
        end
        // Walk downwards so the lowest index wins.
        for (int k = NUM_CELLS - 1; k >= 0; k--) begin
            if (acc[k])
                hit_idx_d = IDX_W'(k);
            if (cell_dr_d[k])
                rgb_d = DIGIT_RGB;
        end
        any_dr_d    = |cell_dr_d;
        hit_pulse_d = |acc;
        score_sum   = {1'b0, score_q} + {1'b0, hit_sum};
        score_d     = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < COLS; c++)
                x_q[c] <= 32'((INITIAL_X + c * X_PITCH) * (2 ** FRAC));
            for (int k = 0; k < NUM_CELLS; k++) begin
                st_q[k]  <= ST_VIS;
                tmr_q[k] <= '0;
            end
            hit_prev_q  <= '0;
            cell_dr_q   <= '0;
            any_dr_q    <= 1'b0;
            rgb_q       <= '0;
            hit_pulse_q <= 1'b0;
            hit_idx_q   <= '0;
            score_q     <= '0;
        end else begin
            for (int c = 0; c < COLS; c++)
                x_q[c] <= x_d[c];
            for (int k = 0; k < NUM_CELLS; k++) begin
                st_q[k]  <= st_d[k];
                tmr_q[k] <= tmr_d[k];
            end
            hit_prev_q  <= singleHit;
            cell_dr_q   <= cell_dr_d;
            any_dr_q    <= any_dr_d;
            rgb_q       <= rgb_d;
            hit_pulse_q <= hit_pulse_d;
            hit_idx_q   <= hit_idx_d;
            score_q     <= score_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CELLS; k++)
            showMask[k] = (st_q[k] == ST_VIS);
    end

    assign cellDR   = cell_dr_q;
    assign anyDR    = any_dr_q;
    assign rgbOut   = rgb_q;
    assign hitPulse = hit_pulse_q;
    assign hitIdx   = hit_idx_q;
    assign score    = score_q;

endmodule

// File: doc/number_grid_display.md
Name: number_grid_display

Overview:
Parametrised successor to the per-column number display. It draws a ROWS x COLS grid of digit sprites. Each column scrolls horizontally with its own signed fixed-point speed and wraps around the screen. Each cell hides after a hit, blinks before it reappears, and adds its digit value to a running score. Pixel drawing requests and colours are merged into a single priority-resolved output, which feeds the top-level object mux.

Parameters:
ROWS, 3, cells per column
COLS, 2, number of scrolling columns
NUM_CELLS, ROWS*COLS, derived; cell k = r*COLS + c
INITIAL_X, 150, reset X (pixels) of column 0
X_PITCH, 50, reset X spacing between columns
Y0, 100, Y of row 0
Y_PITCH, 100, Y spacing between rows
SPRITE_W, 16, digit sprite width (pixels)
SPRITE_H, 32, digit sprite height (pixels)
SCREEN_W, 640, horizontal wrap modulus (pixels)
FRAC, 6, fractional bits in position and speed
HIDE_FRAMES, 450, frames a cell stays unavailable after a hit
BLINK_FRAMES, 64, final frames of HIDE_FRAMES during which the cell blinks
DIGIT_RGB, 8'hFF, colour of lit digit pixels

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per frame
pixelX  in  11  current VGA X
pixelY  in  11  current VGA Y
digits  in  NUM_CELLS*4  digit value per cell (0-9; 10-15 draw blank)
colSpeed  in  COLS*32  signed speed per column, pixels*2^FRAC per frame
singleHit  in  NUM_CELLS  level collision flag per cell
cellDR  out  NUM_CELLS  registered per-cell draw request
anyDR  out  1  OR of cellDR
rgbOut  out  8  colour of lowest-index requesting cell, else 0
showMask  out  NUM_CELLS  1 = cell collidable (VISIBLE)
hitPulse  out  1  one-cycle pulse on any accepted hit
hitIdx  out  $clog2(NUM_CELLS)  lowest accepted hit index, held until next hit
score  out  16  saturating sum of collected digit values

Behaviour:
- The reset is synchronous and active-high. While it is asserted:
  - column c X = (INITIAL_X + c*X_PITCH) << FRAC
  - all cells VISIBLE, timers 0
  - score 0, hitIdx 0, hitPulse 0
  - cellDR, anyDR and rgbOut 0; showMask all 1
  - singleHit edge registers cleared.
  - Reset asserted mid-hide aborts the hide; the cell is VISIBLE on the first cycle after reset.
- Column motion: on startOfFrame, X[c] += sign-extended colSpeed[c].
  - If the integer part is >= SCREEN_W, subtract SCREEN_W<<FRAC.
  - If the result is negative, add SCREEN_W<<FRAC.
  - Speeds of magnitude >= SCREEN_W<<FRAC are out of range; the block does not check them.
- Cell geometry: top-left is (X[c]>>FRAC, Y0 + r*Y_PITCH). Horizontal wrap is not split across the edge; the sprite is clipped at SCREEN_W.
- Hit detection:
  - An accepted hit is a rising edge of singleHit[k] (registered previous value) while cell k is VISIBLE.
  - Edges while HIDDEN or BLINK are ignored. A level held high across reappearance does not re-trigger until it falls and rises again.
- Per-cell FSM, with a 9+ bit timer:
  - VISIBLE -> HIDDEN on accepted hit; timer = HIDE_FRAMES.
  - HIDDEN: timer decrements on startOfFrame. Move to BLINK when the timer <= BLINK_FRAMES.
  - BLINK: the timer keeps decrementing. Return to VISIBLE when the timer reaches 0.
  - A hit in the same cycle as startOfFrame loads HIDE_FRAMES without decrementing.
- Visibility: the cell draws in VISIBLE, and in BLINK when timer[3] == 1 (8-frame on/off). It never draws in HIDDEN. showMask = (state == VISIBLE) only; a blinking cell is not collidable.
- Scoring: on the hit cycle, score += sum of the digit values of all accepted cells (blank digits count 0). The sum saturates at 16'hFFFF.
  - hitPulse is high for exactly that cycle.
  - hitIdx = lowest accepted index. Simultaneous hits are all accepted.
- Drawing has 1-cycle latency: cellDR and rgbOut reflect the pixelX/pixelY of the previous cycle.
  - cellDR[k] = pixel inside the cell rectangle && cell drawn && digit bitmap bit set.
  - The bitmap comes from the shared digit ROM, indexed by (digit, offX, offY).
  - Overlapping cells resolve to the lowest index for rgbOut; cellDR still reports all overlapping cells.

Test Plan:
- Reset with defaults, then scan pixels: cell 0 lit only inside x 150..165, y 100..131; cell 3 inside x 200..215, y 200..231; showMask = 6'b111111.
- colSpeed[0] = +64 (1 px/frame) for 3 frames → column 0 at x 153. colSpeed[1] = -64 with X = 0 → after one frame at 639 (wrapped). Wrap the other way: X = 639, speed +64 → 0.
- digits[2] = 7, pulse singleHit[2] → hitPulse for one cycle, hitIdx = 2, score = 7, showMask[2] = 0. Cell 2 is dark for 386 frames, then blinks 8 on / 8 off, and is VISIBLE again at frame 450.
- Hold singleHit[1] high for 500 frames → exactly one accepted hit; score increments once; the cell reappears and is not re-hit until the level toggles.
- Simultaneous hits on cells 0 and 4 (digits 9, 9), with score preset near 16'hFFF5 → score saturates at FFFF; hitIdx = 0; both cells hidden.
- Hit coincident with startOfFrame → timer = 450, not 449. Assert reset at frame 100 of a hide → cell VISIBLE and drawable the cycle after reset deasserts.
